// File: rtl/rhs2116_spi_responder.sv
// Behavioural RHS2116 SPI slave: oversamples the SPI pins, decodes 32-bit commands and returns
// CONVERT results with two-frame latency. Define RHS2116_RESP_FRAME_ERR_EN for frame_err/err_cnt.
module rhs2116_spi_responder #(
    parameter int unsigned SEQ_W = 12
) (
    input  logic        clk_spi,
    input  logic        rst_n,
    input  logic        cs_n,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic [31:0] cmd_out,
    output logic        cmd_valid,
    output logic [15:0] frame_cnt
`ifdef RHS2116_RESP_FRAME_ERR_EN
    ,
    output logic        frame_err,
    output logic [7:0]  err_cnt
`endif
);

    typedef enum logic [0:0] {ST_IDLE, ST_ACTIVE} state_t;

    state_t            state;
    logic [2:0]        cs_pipe;
    logic [2:0]        sclk_pipe;
    logic [1:0]        mosi_pipe;
    logic [31:0]       rx_shift;
    logic [31:0]       tx_shift;
    logic [5:0]        bit_cnt;
    logic [31:0]       r1;
    logic [31:0]       r2;
    logic [SEQ_W-1:0]  seq;
    logic [11:0]       seq12;
    logic [31:0]       result;

    wire cs_fall   = cs_pipe[2] & ~cs_pipe[1];
    wire cs_rise   = ~cs_pipe[2] & cs_pipe[1];
    wire sclk_rise = ~sclk_pipe[2] & sclk_pipe[1];
    wire sclk_fall = sclk_pipe[2] & ~sclk_pipe[1];
    wire mosi_s    = mosi_pipe[1];

    assign miso_oe = ~cs_pipe[1];

    if (SEQ_W >= 12) begin : g_seq_trunc
        assign seq12 = seq[11:0];
    end else begin : g_seq_ext
        assign seq12 = {{(12 - SEQ_W){1'b0}}, seq};
    end

    // Result of the command currently held in rx_shift, using seq before this frame's increment.
    always_comb begin
        result = 32'hFFFF_0000;
        if (rx_shift[31:30] == 2'b00) begin
            result[31:16] = {rx_shift[19:16], seq12};
            result[15:0]  = rx_shift[27] ? {6'b0, rx_shift[19:16], seq12[5:0]} : 16'h0000;
        end
    end

    always_ff @(posedge clk_spi or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cs_pipe   <= 3'b111;
            sclk_pipe <= 3'b000;
            mosi_pipe <= 2'b00;
            rx_shift  <= 32'h0;
            tx_shift  <= 32'h0;
            bit_cnt   <= 6'd0;
            r1        <= 32'h0;
            r2        <= 32'h0;
            seq       <= '0;
            miso      <= 1'b0;
            cmd_out   <= 32'h0;
            cmd_valid <= 1'b0;
            frame_cnt <= 16'h0;
`ifdef RHS2116_RESP_FRAME_ERR_EN
            frame_err <= 1'b0;
            err_cnt   <= 8'h0;
`endif
        end else begin
            cs_pipe   <= {cs_pipe[1:0], cs_n};
            sclk_pipe <= {sclk_pipe[1:0], sclk};
            mosi_pipe <= {mosi_pipe[0], mosi};
            cmd_valid <= 1'b0;
`ifdef RHS2116_RESP_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
            unique case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state    <= ST_ACTIVE;
                        tx_shift <= r2;
                        miso     <= r2[31];
                        rx_shift <= 32'h0;
                        bit_cnt  <= 6'd0;
                    end
                end
                ST_ACTIVE: begin
                    if (cs_rise) begin
                        state <= ST_IDLE;
                        if (bit_cnt == 6'd32) begin
                            cmd_out   <= rx_shift;
                            cmd_valid <= 1'b1;
                            frame_cnt <= frame_cnt + 16'd1;
                            seq       <= seq + {{(SEQ_W - 1){1'b0}}, 1'b1};
                            r2        <= r1;
                            r1        <= result;
                        end else begin
`ifdef RHS2116_RESP_FRAME_ERR_EN
                            frame_err <= 1'b1;
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
                        end
                    end else if (sclk_rise) begin
                        rx_shift <= {rx_shift[30:0], mosi_s};
                        if (bit_cnt != 6'd33) bit_cnt <= bit_cnt + 6'd1;
                    end else if (sclk_fall && bit_cnt >= 6'd1 && bit_cnt <= 6'd31) begin
                        tx_shift <= {tx_shift[30:0], 1'b0};
                        miso     <= tx_shift[30];
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rhs2116_spi_responder.sv
// Self-checking bench for rhs2116_spi_responder: directed and randomized SPI frames against a
// frame-level reference model of the result pipeline.
module tb_rhs2116_spi_responder;

    localparam int HALF = 5;

    logic        clk_spi = 1'b0;
    logic        rst_n   = 1'b0;
    logic        cs_n    = 1'b1;
    logic        sclk    = 1'b0;
    logic        mosi    = 1'b0;
    logic        miso;
    logic        miso_oe;
    logic [31:0] cmd_out;
    logic        cmd_valid;
    logic [15:0] frame_cnt;
`ifdef RHS2116_RESP_FRAME_ERR_EN
    logic        frame_err;
    logic [7:0]  err_cnt;
`endif

    rhs2116_spi_responder #(.SEQ_W(12)) dut (
        .clk_spi   (clk_spi),
        .rst_n     (rst_n),
        .cs_n      (cs_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .cmd_out   (cmd_out),
        .cmd_valid (cmd_valid),
        .frame_cnt (frame_cnt)
`ifdef RHS2116_RESP_FRAME_ERR_EN
        ,
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk_spi = ~clk_spi;

    int tests = 0;
    int fails = 0;

    // Reference model: results of every valid frame since reset, in order.
    logic [31:0] hist[$];
    int          n_valid = 0;
    int          n_err   = 0;

    function automatic logic [31:0] model_result(input logic [31:0] c, input int seq);
        int ch;
        int lo;
        ch = int'((c >> 16) & 32'hF);
        if ((c >> 30) != 0) return 32'hFFFF_0000;
        lo = (c[27] == 1'b1) ? (ch * 64 + seq % 64) : 0;
        return 32'(ch * 268435456 + (seq % 4096) * 65536 + lo);
    endfunction

    // A frame returns the result of the valid frame two before it.
    function automatic logic [31:0] expected_miso();
        return (n_valid >= 2) ? hist[n_valid - 2] : 32'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_spi);
    endtask

    task automatic run_frame(input logic [31:0] cmd, input int nbits, input string tag);
        logic [31:0] rx;
        logic [31:0] exp;
        logic [31:0] got_cmd;
        int          cmp;
        int          pulses;
        int          errs;
        rx      = 32'h0;
        exp     = expected_miso();
        got_cmd = 32'h0;
        cmp     = (nbits < 32) ? nbits : 32;
        pulses  = 0;
        errs    = 0;
        cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < 32) ? cmd[31 - i] : 1'b0;
            wait_clk(HALF);
            sclk = 1'b1;
            if (i < 32) rx[31 - i] = miso;
            if (i == 0) check({tag, " miso_oe"}, 32'(miso_oe), 32'd1);
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(HALF);
        cs_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_clk(1);
            if (cmd_valid) begin
                pulses++;
                got_cmd = cmd_out;
            end
`ifdef RHS2116_RESP_FRAME_ERR_EN
            if (frame_err) errs++;
`endif
        end
        check({tag, " miso"}, rx >> (32 - cmp), exp >> (32 - cmp));
        if (nbits == 32) begin
            hist.push_back(model_result(cmd, n_valid));
            n_valid++;
            check({tag, " cmd_valid"}, 32'(pulses), 32'd1);
            check({tag, " cmd_out"}, got_cmd, cmd);
        end else begin
            if (n_err < 255) n_err++;
            check({tag, " no cmd_valid"}, 32'(pulses), 32'd0);
        end
        check({tag, " frame_cnt"}, 32'(frame_cnt), 32'(n_valid % 65536));
        check({tag, " miso_oe idle"}, 32'(miso_oe), 32'd0);
`ifdef RHS2116_RESP_FRAME_ERR_EN
        check({tag, " frame_err"}, 32'(errs), (nbits == 32) ? 32'd0 : 32'd1);
        check({tag, " err_cnt"}, 32'(err_cnt), 32'(n_err));
`else
        errs = errs;
`endif
    endtask

    initial begin
        logic [31:0] c;
        int          nb;
        wait_clk(3);
        check("reset miso", 32'(miso), 32'd0);
        check("reset miso_oe", 32'(miso_oe), 32'd0);
        check("reset cmd_out", cmd_out, 32'h0);
        check("reset cmd_valid", 32'(cmd_valid), 32'd0);
        check("reset frame_cnt", 32'(frame_cnt), 32'd0);
        rst_n = 1'b1;
        wait_clk(5);

        run_frame(32'h0800_0000, 32, "conv ch0");
        run_frame(32'h0801_0000, 32, "conv ch1");
        run_frame(32'h0802_0000, 32, "conv ch2");
        run_frame($urandom, 32, "frame4");
        run_frame(32'h6A00_0000, 32, "non-convert");
        run_frame(32'h0835_0000, 32, "ch5 ignore c21:20");
        run_frame(32'h0005_0000, 32, "ch5 D=0");
        run_frame(32'h1234_5678, 20, "short 20");
        run_frame(32'h0803_0000, 32, "after short");
        run_frame(32'h0804_0000, 33, "long 33");
        run_frame(32'h0806_0000, 32, "after long");

        for (int t = 0; t < 30; t++) begin
            c = $urandom;
            if ($urandom_range(0, 1) == 0) c[31:30] = 2'b00;
            nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 34)) : 32;
            run_frame(c, nb, $sformatf("rand%0d", t));
        end

        // Reset in the middle of a frame, after 10 SCLK rising edges.
        cs_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mosi = 1'b1;
            wait_clk(HALF);
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        rst_n = 1'b0;
        wait_clk(1);
        check("midreset miso", 32'(miso), 32'd0);
        check("midreset miso_oe", 32'(miso_oe), 32'd0);
        check("midreset frame_cnt", 32'(frame_cnt), 32'd0);
        check("midreset cmd_out", cmd_out, 32'h0);
        cs_n = 1'b1;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(5);
        hist.delete();
        n_valid = 0;
        n_err   = 0;
        run_frame(32'h0809_0000, 32, "post-reset 1");
        run_frame(32'h080A_0000, 32, "post-reset 2");
        run_frame(32'h080B_0000, 32, "post-reset 3");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
